// File: rtl/vpi_stream_arbiter.sv
// vpi_stream_arbiter: round-robin packet arbiter sharing one VPI bridge stream port among NUM_REQ requesters.
//   Ports: clk, rst (async, active-high); s_valid/s_data/s_last/s_ready per-requester streams
//   (s_data flattened, requester i at [i*DATA_WIDTH +: DATA_WIDTH]); m_valid/m_data/m_last/m_ready/m_id
//   tagged output stream; timeout_err one-cycle pulse on forced release.
//   Optional macro VPI_STREAM_ARBITER_TIMEOUT_EN adds a stall counter that forcibly releases the grant.
module vpi_stream_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 40,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [IW-1:0]                 m_id,
  input  logic                          m_ready,
  output logic                          timeout_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, sel, idx;
  logic found, busy, hs, tout;
  // Search upward from the requester after the last winner, wrapping at NUM_REQ.
  always_comb begin
    sel = last_grant_q;
    idx = last_grant_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && s_valid[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  // Output side is a zero-latency mux driven by the registered grant; all zero while idle.
  always_comb begin
    busy = state_q == BUSY;
    m_valid = busy & s_valid[grant_q];
    m_data = busy ? s_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    m_last = busy & s_last[grant_q];
    m_id = busy ? grant_q : '0;
    s_ready = busy ? (NUM_REQ'(m_ready) << grant_q) : '0;
    hs = m_valid & m_ready;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_grant_d = last_grant_q;
    if (!busy) begin
      if (found) begin
        grant_d = sel;
        last_grant_d = sel;
        state_d = BUSY;
      end
    end else if ((hs && m_last) || tout) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end
`ifdef VPI_STREAM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_err_q, timeout_err_d;
  // last_grant already holds the stalled requester, so after release it has lowest priority.
  always_comb begin
    tout = busy && (cnt_q == CW'(TIMEOUT_CYCLES));
    cnt_d = (busy && !hs && !tout) ? cnt_q + 1'b1 : '0;
    timeout_err_d = tout;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tout = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
